// File: rtl/div.sv
// Iterative 32-bit RISC-V M-extension divider (DIV/DIVU/REM/REMU).
// One restoring shift-subtract step per cycle; fixed 32-cycle latency, divide-by-zero short-circuits.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic [2:0]  op_i,
  input  logic [4:0]  reg_waddr_i,
  input  logic        start_i,
  output logic [31:0] result_o,
  output logic        ready_o,
  output logic        busy_o,
  output logic [4:0]  reg_waddr_o
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    END  = 2'd2
  } state_t;

  state_t state, state_n;

  logic                     accept;
  logic                     step;
  logic [4:0]               count;
  logic                     is_signed;
  logic                     is_rem_in;

  logic signed [DATA_W-1:0] dividend_raw_p0;
  logic [DATA_W-1:0]        divisor_mag_p0;
  logic                     is_rem_p0;
  logic                     neg_q_p0;
  logic                     neg_r_p0;
  logic                     div_zero_p0;
  logic [4:0]               waddr_p0;

  logic [DATA_W-1:0]        quot_p1;
  logic [DATA_W-1:0]        rem_p1;

  logic [DATA_W:0]          rem_shift;
  logic [DATA_W:0]          diff;
  logic [DATA_W-1:0]        final_result;

  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x,
                                                 input logic          signed_op);
    abs_val = (signed_op && x[DATA_W-1]) ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [DATA_W-1:0] sign_fix(input logic [DATA_W-1:0] mag,
                                                  input logic          neg);
    sign_fix = neg ? (~mag + 1'b1) : mag;
  endfunction

  // op_i bit 2 clear decodes as DIVU; bit 0 selects unsigned, bit 1 selects remainder
  assign is_signed = op_i[2] & ~op_i[0];
  assign is_rem_in = op_i[2] & op_i[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    step    = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          accept  = 1'b1;
          state_n = (divisor_i == '0) ? END : CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (count == 5'd31) state_n = END;
      end
      END:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // ---- stage p0: operand capture at the accept edge ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dividend_raw_p0 <= '0;
      divisor_mag_p0  <= '0;
      is_rem_p0       <= 1'b0;
      neg_q_p0        <= 1'b0;
      neg_r_p0        <= 1'b0;
      div_zero_p0     <= 1'b0;
      waddr_p0        <= '0;
    end else if (accept) begin
      dividend_raw_p0 <= dividend_i;
      divisor_mag_p0  <= abs_val(divisor_i, is_signed);
      is_rem_p0       <= is_rem_in;
      neg_q_p0        <= is_signed & (dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1]);
      neg_r_p0        <= is_signed & dividend_i[DATA_W-1];
      div_zero_p0     <= (divisor_i == '0);
      waddr_p0        <= reg_waddr_i;
    end
  end

  // 33-bit compare: the borrow bit decides whether the subtract is kept
  assign rem_shift = {rem_p1, quot_p1[DATA_W-1]};
  assign diff      = rem_shift - {1'b0, divisor_mag_p0};

  // ---- stage p1: iterative shift-subtract ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quot_p1 <= '0;
      rem_p1  <= '0;
      count   <= '0;
    end else if (accept) begin
      quot_p1 <= abs_val(dividend_i, is_signed);
      rem_p1  <= '0;
      count   <= '0;
    end else if (step) begin
      quot_p1 <= {quot_p1[DATA_W-2:0], ~diff[DATA_W]};
      rem_p1  <= diff[DATA_W] ? rem_shift[DATA_W-1:0] : diff[DATA_W-1:0];
      count   <= count + 5'd1;
    end
  end

  // ---- output: sign correction and divide-by-zero results during END ----
  always_comb begin
    if (div_zero_p0)
      final_result = is_rem_p0 ? dividend_raw_p0 : '1;
    else if (is_rem_p0)
      final_result = sign_fix(rem_p1, neg_r_p0);
    else
      final_result = sign_fix(quot_p1, neg_q_p0);
  end

  assign ready_o     = (state == END);
  assign busy_o      = (state != IDLE);
  assign result_o    = ready_o ? final_result : '0;
  assign reg_waddr_o = ready_o ? waddr_p0 : '0;

endmodule
